// File: rtl/mr_pkg.sv
// mr_pkg: shared types and constants for the writeback / register-file slice.
//   t_regsel : register select (`REGSEL_BITS wide)
//   REG_ZERO : the hard-wired zero register x0
//   t_claim  : {register, valid} pair used for scoreboard claim/retire events
// `XLEN and `REGSEL_BITS default to 32 and 5 unless defined on the command line.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REGSEL_BITS
`define REGSEL_BITS 5
`endif

package mr_pkg;
  localparam int XLEN        = `XLEN;
  localparam int REGSEL_BITS = `REGSEL_BITS;
  localparam int NREGS       = 1 << REGSEL_BITS;

  typedef logic [`REGSEL_BITS-1:0] t_regsel;

  localparam t_regsel REG_ZERO = '0;

  // The register field cannot be called "reg" (reserved word), hence rsel.
  typedef struct packed {
    t_regsel rsel;
    logic    valid;
  } t_claim;

  // Build a claim/retire event; anything aimed at x0 is never valid.
  function automatic t_claim mk_claim(input logic en, input t_regsel r);
    t_claim c;
    c.rsel  = r;
    c.valid = en && (r != REG_ZERO);
    return c;
  endfunction
endpackage

// File: rtl/mr_scoreboard.sv
// mr_scoreboard: one busy bit per register, set on claim, cleared on retire.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   claim_i / claim_reg_i         EX hands an op with this destination to load/store
//   retire_i / retire_reg_i       writeback of this destination (retires older claim)
//   look_a_i / look_b_i           lookup selects
//   look_*_pre_o                  busy bit before this cycle's claim/retire
//   look_*_post_o                 busy bit after this cycle's claim/retire (bypass view)
//   busy_any_o                    OR of all busy bits
// x0 never goes busy. Claim beats retire on the same register: the write
// retires the older op while the claim belongs to the newer one.
module mr_scoreboard
  import mr_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   claim_i,
  input  logic [REGSEL_BITS-1:0] claim_reg_i,
  input  logic                   retire_i,
  input  logic [REGSEL_BITS-1:0] retire_reg_i,
  input  logic [REGSEL_BITS-1:0] look_a_i,
  input  logic [REGSEL_BITS-1:0] look_b_i,
  output logic                   look_a_pre_o,
  output logic                   look_a_post_o,
  output logic                   look_b_pre_o,
  output logic                   look_b_post_o,
  output logic                   busy_any_o
);
  t_claim claim;
  t_claim retire;
  assign claim  = mk_claim(claim_i, claim_reg_i);
  assign retire = mk_claim(retire_i, retire_reg_i);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_d[gi] = 1'b0;
      end else begin : g_live
        logic hit_claim;
        logic hit_retire;
        assign hit_claim  = claim.valid  && (claim.rsel  == t_regsel'(gi));
        assign hit_retire = retire.valid && (retire.rsel == t_regsel'(gi));
        assign busy_d[gi] = hit_claim || (busy_q[gi] && !hit_retire);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign look_a_pre_o  = busy_q[look_a_i];
  assign look_a_post_o = busy_d[look_a_i];
  assign look_b_pre_o  = busy_q[look_b_i];
  assign look_b_post_o = busy_d[look_b_i];
  assign busy_any_o    = |busy_q;

`ifndef SYNTHESIS
  // Claiming a register that is still busy means EX failed to stall,
  // unless the same cycle's writeback retires the older op.
  always_ff @(posedge clk) begin
    if (rst && claim.valid && !(retire.valid && retire.rsel == claim.rsel))
      assert (!busy_q[claim.rsel]);
  end
`endif

`ifdef FORMAL
  always_comb begin
    assert ($countones(busy_q) <= NREGS - 1);
    assert (!busy_q[0]);
  end
`endif
endmodule

// File: rtl/mr_regfile_wb.sv
// mr_regfile_wb: writeback stage + integer register file with RAW scoreboard.
// Ports:
//   clk, rst (sync, active-low)
//   wb_write_i, wb_payload_i, wb_dst_reg_i   writeback from load/store
//   claim_i, claim_reg_i                     destination claimed by EX
//   rd_en_i, rs1_sel_i, rs2_sel_i            read request (1-cycle latency)
//   rd_valid_o                               outputs below valid this cycle
//   rs1_data_o, rs2_data_o                   read data (held when no read)
//   rs1_busy_o, rs2_busy_o                   register has an unretired claim
//   busy_any_o                               any register busy
// Optional build macro MR_RF_BYPASS_EN: a read colliding with a same-cycle
// write returns the write data and the post-write busy bit. Without it the
// read returns the old value with the pre-write busy bit.
module mr_regfile_wb
  import mr_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_write_i,
  input  logic [XLEN-1:0]        wb_payload_i,
  input  logic [REGSEL_BITS-1:0] wb_dst_reg_i,
  input  logic                   claim_i,
  input  logic [REGSEL_BITS-1:0] claim_reg_i,
  input  logic                   rd_en_i,
  input  logic [REGSEL_BITS-1:0] rs1_sel_i,
  input  logic [REGSEL_BITS-1:0] rs2_sel_i,
  output logic                   rd_valid_o,
  output logic [XLEN-1:0]        rs1_data_o,
  output logic [XLEN-1:0]        rs2_data_o,
  output logic                   rs1_busy_o,
  output logic                   rs2_busy_o,
  output logic                   busy_any_o
);
`ifdef MR_RF_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  // Writes during reset and writes to x0 are dropped.
  logic wr_live;
  assign wr_live = rst && wb_write_i && (wb_dst_reg_i != REG_ZERO);

  // Register storage is intentionally not reset.
  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (wr_live) regs_q[wb_dst_reg_i] <= wb_payload_i;
  end

  logic [REGSEL_BITS-1:0] sel [2];
  logic [1:0]             busy_pre;
  logic [1:0]             busy_post;
  assign sel[0] = rs1_sel_i;
  assign sel[1] = rs2_sel_i;

  mr_scoreboard u_sb (
    .clk          (clk),
    .rst          (rst),
    .claim_i      (claim_i),
    .claim_reg_i  (claim_reg_i),
    .retire_i     (wb_write_i),
    .retire_reg_i (wb_dst_reg_i),
    .look_a_i     (rs1_sel_i),
    .look_b_i     (rs2_sel_i),
    .look_a_pre_o (busy_pre[0]),
    .look_a_post_o(busy_post[0]),
    .look_b_pre_o (busy_pre[1]),
    .look_b_post_o(busy_post[1]),
    .busy_any_o   (busy_any_o)
  );

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [XLEN-1:0] data_d;
      logic [XLEN-1:0] data_q;
      logic            busy_d;
      logic            busy_q;
      logic            wr_hit;

      assign wr_hit = wr_live && (wb_dst_reg_i == sel[gi]);

      always_comb begin
        data_d = regs_q[sel[gi]];
        if (BYPASS_EN && wr_hit) data_d = wb_payload_i;
        if (sel[gi] == REG_ZERO) data_d = '0;
        // Without bypass, stale data is paired with the pre-write busy bit.
        busy_d = BYPASS_EN ? busy_post[gi] : busy_pre[gi];
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          data_q <= '0;
          busy_q <= 1'b0;
        end else if (rd_en_i) begin
          data_q <= data_d;
          busy_q <= busy_d;
        end
      end
    end
  endgenerate

  logic rd_valid_q;
  always_ff @(posedge clk) begin
    if (!rst) rd_valid_q <= 1'b0;
    else      rd_valid_q <= rd_en_i;
  end

  assign rd_valid_o = rd_valid_q;
  assign rs1_data_o = g_port[0].data_q;
  assign rs2_data_o = g_port[1].data_q;
  assign rs1_busy_o = g_port[0].busy_q;
  assign rs2_busy_o = g_port[1].busy_q;
endmodule

// File: tb/tb_mr_regfile_wb.sv
module tb_mr_regfile_wb;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_write_i = 1'b0;
  logic [31:0] wb_payload_i = '0;
  logic [4:0]  wb_dst_reg_i = '0;
  logic        claim_i = 1'b0;
  logic [4:0]  claim_reg_i = '0;
  logic        rd_en_i = 1'b0;
  logic [4:0]  rs1_sel_i = '0;
  logic [4:0]  rs2_sel_i = '0;
  logic        rd_valid_o;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic        rs1_busy_o;
  logic        rs2_busy_o;
  logic        busy_any_o;

  mr_regfile_wb dut (
    .clk         (clk),
    .rst         (rst),
    .wb_write_i  (wb_write_i),
    .wb_payload_i(wb_payload_i),
    .wb_dst_reg_i(wb_dst_reg_i),
    .claim_i     (claim_i),
    .claim_reg_i (claim_reg_i),
    .rd_en_i     (rd_en_i),
    .rs1_sel_i   (rs1_sel_i),
    .rs2_sel_i   (rs2_sel_i),
    .rd_valid_o  (rd_valid_o),
    .rs1_data_o  (rs1_data_o),
    .rs2_data_o  (rs2_data_o),
    .rs1_busy_o  (rs1_busy_o),
    .rs2_busy_o  (rs2_busy_o),
    .busy_any_o  (busy_any_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int txn      = 0;

  // Reference model: register contents (with known flags), busy set, held outputs.
  logic [31:0] m_regs  [32];
  bit          m_known [32];
  bit          m_busy  [32];
  bit          m_v;
  logic [31:0] m_d [2];
  bit          m_k [2];
  bit          m_b [2];

  typedef struct {
    logic        r;
    logic        wr;
    logic [31:0] pay;
    logic [4:0]  dst;
    logic        cl;
    logic [4:0]  creg;
    logic        rd;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        e_v;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    logic        e_b1;
    logic        e_b2;
    logic        e_any;
    logic        k1;
    logic        k2;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(input logic r, wr, input logic [31:0] pay, input logic [4:0] dst,
                              input logic cl, input logic [4:0] creg, input logic rd,
                              input logic [4:0] s1, s2, input logic e_v,
                              input logic [31:0] e_d1, e_d2, input logic e_b1, e_b2, e_any, k1, k2);
    vec_t v;
    v.r = r; v.wr = wr; v.pay = pay; v.dst = dst; v.cl = cl; v.creg = creg;
    v.rd = rd; v.s1 = s1; v.s2 = s2; v.e_v = e_v; v.e_d1 = e_d1; v.e_d2 = e_d2;
    v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_any = e_any; v.k1 = k1; v.k2 = k2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s txn %0d: got %h, expected %h", nm, txn, act, exp);
    end
  endtask

  // Expected result of reading one register, given this cycle's write/claim.
  task automatic model_read(input logic [4:0] s, input logic wr, input logic [4:0] dst,
                            input logic [31:0] pay, input logic cl, input logic [4:0] creg,
                            output logic [31:0] d, output bit k, output bit b);
    bit wr_same, cl_same;
    wr_same = wr && (dst == s);
    cl_same = cl && (creg == s);
    if (s == 5'd0) begin
      d = '0; k = 1'b1; b = 1'b0;
    end else begin
`ifdef MR_RF_BYPASS_EN
      if (wr_same) begin d = pay; k = 1'b1; end
      else begin d = m_regs[s]; k = m_known[s]; end
      b = cl_same ? 1'b1 : (wr_same ? 1'b0 : m_busy[s]);
`else
      d = m_regs[s]; k = m_known[s]; b = m_busy[s];
`endif
    end
  endtask

  task automatic step(input logic r, wr, input logic [31:0] pay, input logic [4:0] dst,
                      input logic cl, input logic [4:0] creg, input logic rd,
                      input logic [4:0] s1, s2);
    bit any;
    rst = r; wb_write_i = wr; wb_payload_i = pay; wb_dst_reg_i = dst;
    claim_i = cl; claim_reg_i = creg; rd_en_i = rd; rs1_sel_i = s1; rs2_sel_i = s2;
    if (!r) begin
      m_v = 1'b0;
      for (int p = 0; p < 2; p++) begin m_d[p] = '0; m_k[p] = 1'b1; m_b[p] = 1'b0; end
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      m_v = rd;
      if (rd) begin
        model_read(s1, wr, dst, pay, cl, creg, m_d[0], m_k[0], m_b[0]);
        model_read(s2, wr, dst, pay, cl, creg, m_d[1], m_k[1], m_b[1]);
      end
      if (wr && dst != 5'd0) begin
        m_regs[dst] = pay; m_known[dst] = 1'b1; m_busy[dst] = 1'b0;
      end
      if (cl && creg != 5'd0) m_busy[creg] = 1'b1;
    end
    any = 1'b0;
    for (int i = 0; i < 32; i++) any |= m_busy[i];
    @(posedge clk);
    #1;
    $display("txn %0d rst=%0b wr=%0b x%0d=%h cl=%0b x%0d rd=%0b %0d/%0d -> v=%0b d1=%h d2=%h b=%0b%0b any=%0b",
             txn, r, wr, dst, pay, cl, creg, rd, s1, s2,
             rd_valid_o, rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, busy_any_o);
    chk("model_rd_valid", rd_valid_o, m_v);
    if (m_k[0]) chk("model_rs1_data", rs1_data_o, m_d[0]);
    if (m_k[1]) chk("model_rs2_data", rs2_data_o, m_d[1]);
    chk("model_rs1_busy", rs1_busy_o, m_b[0]);
    chk("model_rs2_busy", rs2_busy_o, m_b[1]);
    chk("model_busy_any", busy_any_o, any);
    if (s1 == s2 && rd && r) begin
      chk("same_sel_data", rs1_data_o, rs2_data_o);
      chk("same_sel_busy", rs1_busy_o, rs2_busy_o);
    end
  endtask

  initial begin
    logic        r, wr, cl, rd;
    logic [31:0] pay;
    logic [4:0]  dst, creg, s1, s2;

    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0; m_known[i] = (i == 0); m_busy[i] = 1'b0;
    end

    //            r wr pay           dst cl creg rd s1  s2   v d1            d2            b1 b2 any k1 k2
    vecs[0]  = mk(0, 0, 32'h0,        0, 0, 0,   0, 0,  0,   0, 32'h0,        32'h0,        0, 0, 0, 1, 1);
    vecs[1]  = mk(0, 0, 32'h0,        0, 0, 0,   0, 0,  0,   0, 32'h0,        32'h0,        0, 0, 0, 1, 1);
    vecs[2]  = mk(1, 0, 32'h0,        0, 0, 0,   1, 0,  0,   1, 32'h0,        32'h0,        0, 0, 0, 1, 1);
    vecs[3]  = mk(1, 1, 32'hDEADBEEF, 5, 0, 0,   0, 0,  0,   0, 32'h0,        32'h0,        0, 0, 0, 1, 1);
    vecs[4]  = mk(1, 0, 32'h0,        0, 0, 0,   1, 5,  5,   1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 1, 1);
    vecs[5]  = mk(1, 0, 32'h0,        0, 1, 7,   0, 0,  0,   0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1, 1, 1);
    vecs[6]  = mk(1, 0, 32'h0,        0, 0, 0,   1, 7,  5,   1, 32'h0,        32'hDEADBEEF, 1, 0, 1, 0, 1);
    vecs[7]  = mk(1, 1, 32'h1234,     7, 0, 0,   0, 0,  0,   0, 32'h0,        32'hDEADBEEF, 1, 0, 0, 0, 1);
    vecs[8]  = mk(1, 0, 32'h0,        0, 0, 0,   1, 7,  7,   1, 32'h1234,     32'h1234,     0, 0, 0, 1, 1);
    vecs[9]  = mk(1, 1, 32'h55,       7, 1, 7,   0, 0,  0,   0, 32'h1234,     32'h1234,     0, 0, 1, 1, 1);
    vecs[10] = mk(1, 0, 32'h0,        0, 0, 0,   1, 7,  0,   1, 32'h55,       32'h0,        1, 0, 1, 1, 1);
    vecs[11] = mk(1, 1, 32'hFFFFFFFF, 0, 1, 0,   1, 0,  0,   1, 32'h0,        32'h0,        0, 0, 1, 1, 1);
`ifdef MR_RF_BYPASS_EN
    vecs[12] = mk(1, 1, 32'h77,       7, 0, 0,   1, 0,  7,   1, 32'h0,        32'h77,       0, 0, 0, 1, 1);
`else
    vecs[12] = mk(1, 1, 32'h77,       7, 0, 0,   1, 0,  7,   1, 32'h0,        32'h55,       0, 1, 0, 1, 1);
`endif
    vecs[13] = mk(1, 1, 32'h11111111, 3, 0, 0,   1, 0,  0,   1, 32'h0,        32'h0,        0, 0, 0, 1, 1);
`ifdef MR_RF_BYPASS_EN
    vecs[14] = mk(1, 1, 32'hA5A5A5A5, 3, 0, 0,   1, 3,  3,   1, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0, 1, 1);
`else
    vecs[14] = mk(1, 1, 32'hA5A5A5A5, 3, 0, 0,   1, 3,  3,   1, 32'h11111111, 32'h11111111, 0, 0, 0, 1, 1);
`endif
    vecs[15] = mk(1, 0, 32'h0,        0, 1, 3,   1, 0,  0,   1, 32'h0,        32'h0,        0, 0, 1, 1, 1);
`ifdef MR_RF_BYPASS_EN
    vecs[16] = mk(1, 1, 32'h22222222, 3, 0, 0,   1, 3,  5,   1, 32'h22222222, 32'hDEADBEEF, 0, 0, 0, 1, 1);
`else
    vecs[16] = mk(1, 1, 32'h22222222, 3, 0, 0,   1, 3,  5,   1, 32'hA5A5A5A5, 32'hDEADBEEF, 1, 0, 0, 1, 1);
`endif
    vecs[17] = mk(1, 0, 32'h0,        0, 1, 9,   1, 0,  0,   1, 32'h0,        32'h0,        0, 0, 1, 1, 1);
    vecs[18] = mk(1, 0, 32'h0,        0, 1, 10,  1, 0,  0,   1, 32'h0,        32'h0,        0, 0, 1, 1, 1);
    vecs[19] = mk(1, 0, 32'h0,        0, 1, 11,  1, 0,  0,   1, 32'h0,        32'h0,        0, 0, 1, 1, 1);
    vecs[20] = mk(0, 1, 32'hBAD,      9, 0, 0,   1, 9,  9,   0, 32'h0,        32'h0,        0, 0, 0, 1, 1);
    vecs[21] = mk(1, 0, 32'h0,        0, 0, 0,   1, 9,  10,  1, 32'h0,        32'h0,        0, 0, 0, 0, 0);
    vecs[22] = mk(1, 1, 32'h900D,     9, 0, 0,   0, 0,  0,   0, 32'h0,        32'h0,        0, 0, 0, 0, 0);
    vecs[23] = mk(1, 0, 32'h0,        0, 0, 0,   1, 9,  11,  1, 32'h900D,     32'h0,        0, 0, 0, 1, 0);

    // Directed vectors: each row's expectations are sampled after its own edge.
    for (int i = 0; i < 24; i++) begin
      txn = i;
      step(vecs[i].r, vecs[i].wr, vecs[i].pay, vecs[i].dst, vecs[i].cl, vecs[i].creg,
           vecs[i].rd, vecs[i].s1, vecs[i].s2);
      chk("vec_rd_valid", rd_valid_o, vecs[i].e_v);
      if (vecs[i].k1) chk("vec_rs1_data", rs1_data_o, vecs[i].e_d1);
      if (vecs[i].k2) chk("vec_rs2_data", rs2_data_o, vecs[i].e_d2);
      chk("vec_rs1_busy", rs1_busy_o, vecs[i].e_b1);
      chk("vec_rs2_busy", rs2_busy_o, vecs[i].e_b2);
      chk("vec_busy_any", busy_any_o, vecs[i].e_any);
    end

    // Fill every register so all later reads have a known expected value.
    for (int i = 1; i < 32; i++) begin
      txn++;
      step(1'b1, 1'b1, $urandom, 5'(i), 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    end

    // Randomized traffic concentrated on a few registers to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      txn++;
      r    = ($urandom_range(0, 49) != 0);
      wr   = $urandom_range(0, 1) == 1;
      pay  = $urandom;
      dst  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      cl   = $urandom_range(0, 2) == 0;
      creg = ($urandom_range(0, 3) == 0) ? dst : 5'($urandom_range(0, 7));
      if (cl && r && creg != 5'd0 && m_busy[creg] && !(wr && dst == creg)) cl = 1'b0;
      rd   = $urandom_range(0, 3) != 0;
      s1   = ($urandom_range(0, 2) == 0) ? dst : 5'($urandom_range(0, 7));
      s2   = ($urandom_range(0, 3) == 0) ? s1  : 5'($urandom_range(0, 7));
      step(r, wr, pay, dst, cl, creg, rd, s1, s2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
